// File: rtl/dram_device_model.sv
// Single-bank DRAM device model: RAS/CAS command decode, tRP/tRCD enforcement,
// byte-masked writes, CAS-latency read pipeline and a sticky protocol error flag.
module dram_device_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int T_RP     = 5,
    parameter int T_RCD    = 5,
    parameter int CAS_LAT  = 5
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        CMD_ERR
);

    localparam int TMAX = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = ROW_BITS + COL_BITS;

    typedef enum logic [1:0] {
        CLOSED,
        ACTIVATING,
        ACTIVE,
        PRECHARGING
    } bank_t;

    bank_t               state;
    bank_t               cur;
    logic [ROW_BITS-1:0] open_row;
    logic [TW-1:0]       tcnt;
    logic [31:0]         mem [2**AW];
    logic [AW-1:0]       widx;

    logic cmd_act, cmd_pre, cmd_rd, cmd_wr;
    logic ok_act, ok_pre, ok_rd, ok_wr, bad;

    always_comb begin
        cmd_act = !CSn && !RASn && CASn && (WEn == 4'hF);
        cmd_pre = !CSn && !RASn && CASn && (WEn == 4'h0);
        cmd_rd  = !CSn && RASn && !CASn && (WEn == 4'hF);
        cmd_wr  = !CSn && RASn && !CASn && (WEn != 4'hF);
    end

    // A timer that has run out counts as already in the settled state, so a
    // command exactly T_RP/T_RCD cycles after its predecessor is accepted.
    always_comb begin
        cur = state;
        if (tcnt == '0) begin
            if (state == PRECHARGING)
                cur = CLOSED;
            else if (state == ACTIVATING)
                cur = ACTIVE;
        end
    end

    always_comb begin
        ok_act = cmd_act && (cur == CLOSED);
        ok_pre = cmd_pre && (cur != ACTIVATING);
        ok_rd  = cmd_rd && (cur == ACTIVE);
        ok_wr  = cmd_wr && (cur == ACTIVE);
        bad    = (cmd_act && !ok_act) || (cmd_pre && !ok_pre) ||
                 (cmd_rd && !ok_rd) || (cmd_wr && !ok_wr);
        widx   = {open_row, A[COL_BITS-1:0]};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ACTIVE;
            open_row <= '0;
            tcnt     <= '0;
            CMD_ERR  <= 1'b0;
        end else begin
            CMD_ERR <= CMD_ERR | bad;
            unique case (1'b1)
                ok_act: begin
                    state    <= ACTIVATING;
                    open_row <= A[ROW_BITS-1:0];
                    tcnt     <= TW'(T_RCD - 1);
                end
                ok_pre: begin
                    state <= PRECHARGING;
                    tcnt  <= TW'(T_RP - 1);
                end
                default: begin
                    state <= cur;
                    if (tcnt != '0)
                        tcnt <= tcnt - 1'b1;
                end
            endcase
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge ACLK) begin
        if (ARESETn && ok_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEn[i])
                    mem[widx][8*i +: 8] <= D[8*i +: 8];
            end
        end
    end

    logic        rd_v;
    logic [31:0] rd_d;
    logic        pv;
    logic [31:0] pd;

    assign rd_v = ok_rd;
    assign rd_d = mem[widx];

    if (CAS_LAT == 1) begin : g_direct
        assign pv = rd_v;
        assign pd = rd_d;
    end else begin : g_pipe
        logic [CAS_LAT-2:0] sv;
        logic [31:0]        sd [CAS_LAT-1];

        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                sv <= '0;
                for (int i = 0; i < CAS_LAT - 1; i++)
                    sd[i] <= '0;
            end else begin
                sv[0] <= rd_v;
                sd[0] <= rd_d;
                for (int i = 1; i < CAS_LAT - 1; i++) begin
                    sv[i] <= sv[i-1];
                    sd[i] <= sd[i-1];
                end
            end
        end

        assign pv = sv[CAS_LAT-2];
        assign pd = sd[CAS_LAT-2];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            VALID <= 1'b0;
            Q     <= '0;
        end else begin
            VALID <= pv;
            if (pv)
                Q <= pd;
        end
    end

endmodule
